imuldiv_muldiv_resp_queue: RTL
==============================

Name: imuldiv_muldiv_resp_queue

Overview:
Response-side stage directly downstream of the iterative mul/div unit. It records fn and destination register for each request the unit accepts. On each 64-bit response it selects the architecturally visible 32-bit word and buffers {dest, word} in a small FIFO. It also gates the request handshake so the in-flight tag count never exceeds the tag FIFO capacity. Output feeds the writeback arbiter.

Parameters:
DEPTH, 2, entries in the tag FIFO and in the result FIFO; power of two, 2..8
DEST_W, 5, destination register tag width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
issue_fn  in  3  request fn code (MUL=0 DIV=1 DIVU=2 REM=3 REMU=4 MULH=5 MULHSU=6 MULHU=7)
issue_dest  in  DEST_W  destination register of request
issue_val  in  1  upstream request valid
issue_rdy  out  1  to upstream: muldivreq_rdy && !tag_full
muldivreq_val  out  1  to unit: issue_val && !tag_full
muldivreq_rdy  in  1  from unit
muldivresp_msg_result  in  64  from unit
muldivresp_val  in  1  from unit
muldivresp_rdy  out  1  to unit: !res_full && !tag_empty
wb_data  out  32  selected result word
wb_dest  out  DEST_W  destination tag
wb_val  out  1  result FIFO non-empty
wb_rdy  in  1  writeback accept
orphan_err  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- Reset (reset==0, async): both FIFOs empty, pointers/counts 0, orphan_err=0, wb_val=0, muldivresp_rdy=0, wb_data/wb_dest=0. issue_rdy and muldivreq_val follow their equations, with tag_full=0.
- Issue fire = issue_val && muldivreq_rdy && !tag_full. On fire, push {issue_fn, issue_dest} into the tag FIFO at the next edge.
- Tag full check uses the registered count only. When full, a same-cycle pop does not permit a push.
- Response fire = muldivresp_val && muldivresp_rdy. On fire:
  - pop the tag FIFO head;
  - push {head.dest, sel} into the result FIFO.
- Word select, with the result interpreted as {hi[63:32], lo[31:0]}:
  - MUL, DIV, DIVU -> lo
  - MULH, MULHSU, MULHU, REM, REMU -> hi
  - Division packing is {remainder, quotient}.
- Tag FIFO push and pop in the same cycle: count unchanged, both pointers advance. Same rule applies to the result FIFO: wb fire (wb_val && wb_rdy) plus response fire.
- Result FIFO full: muldivresp_rdy=0. The unit holds its response, and the response is not lost.
- muldivresp_val=1 while the tag FIFO is empty: muldivresp_rdy=0, orphan_err set at the next edge and held until reset.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Latency without the optional feature: a response accepted at edge N is visible on wb_val/wb_data after edge N; minimum 1 cycle.
- Ordering: strict FIFO. Responses must return in issue order, which the single-outstanding unit guarantees.
- wb_data/wb_dest come from the registered FIFO head and are stable while wb_val && !wb_rdy.
- Reset mid-operation: all entries discarded. No wb_val pulse follows deassertion until a new issue/response pair completes.

Optional Feature:
IMULDIV_RESP_BYPASS_EN
- Defined: when the result FIFO is empty and wb_rdy=1, a response passes combinationally to wb_data/wb_dest/wb_val in the same cycle.
  - Not pushed into the FIFO; tag still popped.
  - muldivresp_rdy becomes (!res_full || wb_rdy) && !tag_empty.
  - Zero-cycle latency.
- Undefined: no combinational path from muldivresp_* to wb_*; behaviour as above.

Test Plan:
- Reset low mid-stream with 2 tags queued and 1 result buffered -> after release: wb_val=0, issue_rdy=muldivreq_rdy, orphan_err=0.
- Issue MUL dest=3 a=7 b=-2; unit returns 64'hFFFFFFFF_FFFFFFF2 -> one wb beat: wb_data=32'hFFFFFFF2, wb_dest=3, one cycle after response fire.
- Issue MULHU dest=9 a=b=32'hFFFFFFFF; result 64'hFFFFFFFE_00000001 -> wb_data=32'hFFFFFFFE, wb_dest=9.
- Issue REM dest=4 (-7,2) then DIV dest=5 (-7,2), results {FFFFFFFF,FFFFFFFD} each -> wb beats in order: (4, 32'hFFFFFFFF) then (5, 32'hFFFFFFFD).
- wb_rdy=0, DEPTH=2:
  - two responses fill the result FIFO -> third response held with muldivresp_rdy=0;
  - issue_rdy=0 while 2 tags outstanding;
  - on wb_rdy=1, entries drain one per cycle and the held response is accepted.
- muldivresp_val=1 with no issue -> muldivresp_rdy=0, orphan_err=1 next cycle and remains 1. With IMULDIV_RESP_BYPASS_EN, a MUL response with empty FIFO and wb_rdy=1 -> wb_val=1 the same cycle.

Source files
------------

// File: rtl/imuldiv_muldiv_resp_queue.sv
// ----------------------------------------------------------------------------
// imuldiv_muldiv_resp_queue
//
// Response-side stage behind the iterative mul/div unit.
// - Tag FIFO: holds {fn, dest} for every request the unit has accepted.
//   Requests are throttled so the in-flight count never exceeds DEPTH.
// - Result FIFO: on each unit response, picks the architecturally visible
//   32-bit word (lo for MUL/DIV/DIVU, hi for MULH*/REM*) and buffers it with
//   the destination tag for the writeback arbiter.
// - orphan_err: sticky flag set when the unit offers a response while no tag
//   is outstanding.
//
// Optional feature macro: IMULDIV_RESP_BYPASS_EN
//   When defined, a response arriving while the result FIFO is empty and
//   wb_rdy=1 goes straight to wb_* in the same cycle, and is not stored.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   issue_fn/dest/val/rdy      upstream request handshake
//   muldivreq_val/rdy          request handshake to the unit
//   muldivresp_msg_result/val/rdy  response handshake from the unit
//   wb_data/dest/val/rdy       writeback output handshake
//   orphan_err                 sticky protocol error
// ----------------------------------------------------------------------------
module imuldiv_muldiv_resp_queue #(
    parameter int DEPTH  = 2,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        issue_fn,
    input  logic [DEST_W-1:0] issue_dest,
    input  logic              issue_val,
    output logic              issue_rdy,
    output logic              muldivreq_val,
    input  logic              muldivreq_rdy,
    input  logic [63:0]       muldivresp_msg_result,
    input  logic              muldivresp_val,
    output logic              muldivresp_rdy,
    output logic [31:0]       wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_val,
    input  logic              wb_rdy,
    output logic              orphan_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;

    // ---------------- tag FIFO ----------------
    logic [2:0]        tag_fn   [DEPTH];
    logic [DEST_W-1:0] tag_dest [DEPTH];
    logic [PW-1:0]     tag_wr, tag_rd;
    logic [CW-1:0]     tag_cnt;
    logic              tag_full, tag_empty;
    logic              tag_push, tag_pop;

    // ---------------- result FIFO ----------------
    logic [31:0]       res_data [DEPTH];
    logic [DEST_W-1:0] res_dest [DEPTH];
    logic [PW-1:0]     res_wr, res_rd;
    logic [CW-1:0]     res_cnt;
    logic              res_full, res_empty;
    logic              res_push, res_pop;

    logic              resp_fire;
    logic              byp;
    logic [2:0]        head_fn;
    logic [DEST_W-1:0] head_dest;
    logic [31:0]       sel_word;

    // Full/empty come from registered counts only, so a same-cycle pop never
    // opens a slot for a push in that cycle.
    assign tag_full  = (tag_cnt == CW'(DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign res_full  = (res_cnt == CW'(DEPTH));
    assign res_empty = (res_cnt == '0);

    assign issue_rdy     = muldivreq_rdy && !tag_full;
    assign muldivreq_val = issue_val && !tag_full;
    assign tag_push      = issue_val && muldivreq_rdy && !tag_full;

    assign head_fn   = tag_fn[tag_rd];
    assign head_dest = tag_dest[tag_rd];

    // Divide results are packed {remainder, quotient}, so DIV/DIVU take lo
    // along with MUL; every other fn wants the upper word.
    assign sel_word = (head_fn == FN_MUL || head_fn == FN_DIV || head_fn == FN_DIVU)
                    ? muldivresp_msg_result[31:0]
                    : muldivresp_msg_result[63:32];

`ifdef IMULDIV_RESP_BYPASS_EN
    // A full FIFO can still take a response when the head is leaving this
    // cycle or the response bypasses straight out.
    assign muldivresp_rdy = (!res_full || wb_rdy) && !tag_empty;
    assign resp_fire      = muldivresp_val && muldivresp_rdy;
    assign byp            = resp_fire && res_empty && wb_rdy;
    assign wb_val         = !res_empty || byp;
    assign wb_data        = byp ? sel_word  : res_data[res_rd];
    assign wb_dest        = byp ? head_dest : res_dest[res_rd];
`else
    assign muldivresp_rdy = !res_full && !tag_empty;
    assign resp_fire      = muldivresp_val && muldivresp_rdy;
    assign byp            = 1'b0;
    assign wb_val         = !res_empty;
    assign wb_data        = res_data[res_rd];
    assign wb_dest        = res_dest[res_rd];
`endif

    assign tag_pop  = resp_fire;
    assign res_push = resp_fire && !byp;
    assign res_pop  = !res_empty && wb_rdy;

    // ---------------- tag FIFO state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_fn[i]   <= '0;
                tag_dest[i] <= '0;
            end
        end else begin
            if (tag_push) begin
                tag_fn[tag_wr]   <= issue_fn;
                tag_dest[tag_wr] <= issue_dest;
                tag_wr           <= tag_wr + PW'(1);
            end
            if (tag_pop)
                tag_rd <= tag_rd + PW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- result FIFO state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_wr  <= '0;
            res_rd  <= '0;
            res_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_data[i] <= '0;
                res_dest[i] <= '0;
            end
        end else begin
            if (res_push) begin
                res_data[res_wr] <= sel_word;
                res_dest[res_wr] <= head_dest;
                res_wr           <= res_wr + PW'(1);
            end
            if (res_pop)
                res_rd <= res_rd + PW'(1);
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + CW'(1);
                2'b01:   res_cnt <= res_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- sticky orphan flag ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            orphan_err <= 1'b0;
        else if (muldivresp_val && tag_empty)
            orphan_err <= 1'b1;
    end

endmodule
